// File: rtl/kernel_calc_pkg.sv
// Shared definitions for the kernel-calculation units: sizing helper,
// accumulator FSM encoding and default stream geometry.
package kernel_calc_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 16;
  localparam int unsigned DEFAULT_KERNEL_N = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0 so a single-tap window adds no headroom bits.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kernel_result_fmt.sv
// Scales a window sum by a truncating right shift and saturates or wraps
// it to OUT_W bits, flagging any value that does not fit.
module kernel_result_fmt #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SAT   = 1
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] data,
  output logic             ovf
);

  localparam int unsigned WIDE = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [WIDE-1:0] MAX_OUT = WIDE'({OUT_W{1'b1}});

  logic [WIDE-1:0] sh;

  // When the shifted sum cannot exceed OUT_W bits the compare folds to 0.
  assign sh   = WIDE'(sum >> SHIFT);
  assign ovf  = (sh > MAX_OUT);
  assign data = (ovf && (SAT != 0)) ? {OUT_W{1'b1}} : sh[OUT_W-1:0];

endmodule

// File: rtl/kernel_accumulator.sv
// Sums KERNEL_N-sample windows from a valid/ready stream and presents each
// scaled result on a registered valid/ready output with an overflow flag.
module kernel_accumulator
  import kernel_calc_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned KERNEL_N = DEFAULT_KERNEL_N,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy
);

  localparam int unsigned ACC_W = DATA_W + clog2(KERNEL_N);
  localparam int unsigned CNT_W = (clog2(KERNEL_N) > 0) ? clog2(KERNEL_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_N - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_d;
  logic [OUT_W-1:0]   out_data_d;
  logic               out_ovf_d;

  logic               accept;
  logic [ACC_W-1:0]   sum;
  logic [OUT_W-1:0]   fmt_data;
  logic               fmt_ovf;

  // While a result is held, a new sample may only enter as the result retires.
  assign in_ready = (state_q == ACCUM) ? 1'b1 : out_ready;
  assign accept   = in_valid & in_ready;
  assign sum      = acc_q + ACC_W'(in_data);
  assign busy     = (cnt_q != '0);

  kernel_result_fmt #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_fmt (
    .sum  (sum),
    .data (fmt_data),
    .ovf  (fmt_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_ovf_d   = out_ovf;

    if (clear) begin
      // Abort: drop partial window, pending result and any sample this cycle.
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if ((state_q == HOLD) && out_ready) begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
      end

      if (accept) begin
        if (cnt_q == CNT_LAST) begin
          state_d     = HOLD;
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = fmt_data;
          out_ovf_d   = fmt_ovf;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_ovf   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_kernel_accumulator.sv
// Self-checking bench: four kernel_accumulator configurations share one
// stimulus stream and are checked every cycle against a window-sum model.
module tb_kernel_accumulator;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  of;
  logic [3:0]  bz;
  logic [15:0] od [4];

  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  // Configuration of each instance: taps, shift, saturate.
  int unsigned kn [4] = '{9, 9, 9, 1};
  int unsigned sh [4] = '{0, 0, 4, 0};
  bit          st [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  // Model state: running window, pending result.
  longint unsigned wsum [4];
  int unsigned     wcnt [4];
  bit              pend [4];
  logic [15:0]     res  [4];
  bit              rovf [4];

  kernel_accumulator #(.KERNEL_N(9), .SHIFT(0), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ovf(of[0]), .busy(bz[0]));

  kernel_accumulator #(.KERNEL_N(9), .SHIFT(0), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ovf(of[1]), .busy(bz[1]));

  kernel_accumulator #(.KERNEL_N(9), .SHIFT(4), .SAT(1)) u_shift (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_ovf(of[2]), .busy(bz[2]));

  kernel_accumulator #(.KERNEL_N(1), .SHIFT(0), .SAT(1)) u_one (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]),
    .out_ovf(of[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int k,
                              input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit v, input logic [15:0] d, input bit r,
                            input bit c, input bit rs);
    longint unsigned s;
    bit take;
    for (int k = 0; k < 4; k++) begin
      if (rs) begin
        wsum[k] = 0; wcnt[k] = 0; pend[k] = 0; res[k] = '0; rovf[k] = 0;
      end else if (c) begin
        wsum[k] = 0; wcnt[k] = 0; pend[k] = 0;
      end else begin
        take = v && (!pend[k] || r);
        if (pend[k] && r) pend[k] = 0;
        if (take) begin
          wsum[k] += longint'(d);
          wcnt[k]++;
          if (wcnt[k] == kn[k]) begin
            s       = wsum[k] >> sh[k];
            rovf[k] = (s > 65535);
            res[k]  = (rovf[k] && st[k]) ? 16'hFFFF : 16'(s % 65536);
            pend[k] = 1;
            wsum[k] = 0;
            wcnt[k] = 0;
          end
        end
      end
    end
  endtask

  // One clock: drive at negedge, check in_ready, clock, check registered outputs.
  task automatic cyc(input bit v, input logic [15:0] d, input bit r,
                     input bit c, input bit rs);
    in_valid = v; in_data = d; out_ready = r; clear = c; rst = rs;
    #1;
    for (int k = 0; k < 4; k++) chk("in_ready", k, 64'(ir[k]), 64'(!pend[k] || r));
    model_edge(v, d, r, c, rs);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", k, 64'(ov[k]), 64'(pend[k]));
      chk("out_data",  k, 64'(od[k]), 64'(res[k]));
      chk("out_ovf",   k, 64'(of[k]), 64'(rovf[k]));
      chk("busy",      k, 64'(bz[k]), 64'(wcnt[k] != 0));
    end
    @(negedge clk);
  endtask

  initial begin
    bit v, r, c, rs;
    logic [15:0] d;
    for (int k = 0; k < 4; k++) begin
      wsum[k] = 0; wcnt[k] = 0; pend[k] = 0; res[k] = '0; rovf[k] = 0;
    end
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 0, 64'(ov[0]), 64'd0);
    chk("reset_data",  0, 64'(od[0]), 64'd0);

    // 1..9 sums to 45.
    for (int i = 1; i <= 9; i++) cyc(1, 16'(i), 1, 0, 0);
    chk("sum45_valid", 0, 64'(ov[0]), 64'd1);
    chk("sum45_data",  0, 64'(od[0]), 64'd45);
    chk("sum45_ovf",   0, 64'(of[0]), 64'd0);
    chk("sum45_busy",  0, 64'(bz[0]), 64'd0);
    cyc(0, 0, 1, 0, 0);

    // 9 x 0xFFFF = 589815: saturate, wrap and shift variants.
    for (int i = 0; i < 9; i++) cyc(1, 16'hFFFF, 1, 0, 0);
    chk("max_sat_data",   0, 64'(od[0]), 64'hFFFF);
    chk("max_sat_ovf",    0, 64'(of[0]), 64'd1);
    chk("max_wrap_data",  1, 64'(od[1]), 64'hFFF7);
    chk("max_wrap_ovf",   1, 64'(of[1]), 64'd1);
    chk("max_shift_data", 2, 64'(od[2]), 64'h8FFF);
    chk("max_shift_ovf",  2, 64'(of[2]), 64'd0);
    cyc(0, 0, 1, 0, 0);

    // Backpressure: result 27 held while samples wait, then retire + accept.
    for (int i = 0; i < 9; i++) cyc(1, 16'd3, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'd10, 0, 0, 0);
      chk("hold_data",  0, 64'(od[0]), 64'd27);
      chk("hold_ready", 0, 64'(ir[0]), 64'd0);
    end
    for (int i = 0; i < 9; i++) cyc(1, 16'd10, 1, 0, 0);
    chk("bp_sum90", 0, 64'(od[0]), 64'd90);
    cyc(0, 0, 1, 0, 0);

    // Clear mid-window drops the presented sample.
    for (int i = 0; i < 4; i++) cyc(1, 16'd5, 1, 0, 0);
    cyc(1, 16'd5, 1, 1, 0);
    chk("clear_busy", 0, 64'(bz[0]), 64'd0);
    for (int i = 0; i < 9; i++) cyc(1, 16'd2, 1, 0, 0);
    chk("clear_sum18", 0, 64'(od[0]), 64'd18);
    cyc(0, 0, 1, 0, 0);

    // Reset mid-window and while a result is held.
    for (int i = 0; i < 5; i++) cyc(1, 16'd7, 1, 0, 0);
    cyc(1, 16'd7, 1, 0, 1);
    chk("rst_mid_busy",  0, 64'(bz[0]), 64'd0);
    chk("rst_mid_ready", 0, 64'(ir[0]), 64'd1);
    for (int i = 0; i < 9; i++) cyc(1, 16'd1, 0, 0, 0);
    chk("pre_rst_valid", 0, 64'(ov[0]), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_hold_valid", 0, 64'(ov[0]), 64'd0);
    chk("rst_hold_data",  0, 64'(od[0]), 64'd0);
    chk("rst_hold_ready", 0, 64'(ir[0]), 64'd1);

    // Single-tap instance: back-to-back results.
    for (int i = 7; i <= 9; i++) begin
      cyc(1, 16'(i), 1, 0, 0);
      chk("one_tap_valid", 3, 64'(ov[3]), 64'd1);
      chk("one_tap_data",  3, 64'(od[3]), 64'(i));
    end
    cyc(0, 0, 1, 0, 0);

    // Randomized traffic with occasional clear and reset.
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom % 10) < 7;
      d  = (($urandom % 4) == 0) ? 16'(16'hFFF0 + ($urandom % 16)) : 16'($urandom);
      r  = ($urandom % 10) < 6;
      c  = ($urandom % 100) == 0;
      rs = ($urandom % 200) == 0;
      cyc(v, d, r, c, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
